// File: rtl/switch_event_conditioner.sv
// switch_event_conditioner: synchronise, debounce and edge-detect slide switches,
// then release each rising edge as a single-cycle pulse aligned to the slow tick.
//   clk        fast board clock, all logic on its rising edge
//   reset      synchronous active-high reset, clears every register
//   tick       one-cycle strobe at FSM rate; events are released on it
//   sw_in      raw asynchronous switch levels
//   level_out  debounced level per channel
//   event_out  one-cycle pulse per debounced rising edge, in the cycle after a tick edge
//   overrun    sticky flag: a rising edge arrived while an event was still pending
module switch_event_conditioner #(
    parameter int N_CH      = 9,
    parameter int DB_CYCLES = 1000000,
    parameter int CNT_W     = 20
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            tick,
    input  logic [N_CH-1:0] sw_in,
    output logic [N_CH-1:0] level_out,
    output logic [N_CH-1:0] event_out,
    output logic [N_CH-1:0] overrun
);
    logic [N_CH-1:0]  s1_q, s2_q, level_q, pend_q, ev_q, ovr_q;
    logic [CNT_W-1:0] cnt_q [N_CH];
    logic [N_CH-1:0]  flip, set_now;
    // A channel flips once its synchronised input has disagreed with the
    // debounced level for DB_CYCLES consecutive cycles.
    always_comb begin
        flip = '0;
        for (int i = 0; i < N_CH; i++)
            flip[i] = (s2_q[i] != level_q[i]) && (cnt_q[i] == CNT_W'(DB_CYCLES - 1));
        set_now = flip & ~level_q;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q    <= '0;
            s2_q    <= '0;
            level_q <= '0;
            pend_q  <= '0;
            ev_q    <= '0;
            ovr_q   <= '0;
            for (int i = 0; i < N_CH; i++)
                cnt_q[i] <= '0;
        end else begin
            s1_q    <= sw_in;
            s2_q    <= s1_q;
            level_q <= level_q ^ flip;
            for (int i = 0; i < N_CH; i++)
                cnt_q[i] <= (s2_q[i] == level_q[i] || flip[i]) ? '0 : cnt_q[i] + 1'b1;
            // An edge seen on a tick edge bypasses pending and fires straight away.
            ev_q   <= tick ? (pend_q | set_now) : '0;
            pend_q <= tick ? '0 : (pend_q | set_now);
            ovr_q  <= ovr_q | (tick ? '0 : (set_now & pend_q));
        end
    end
    assign level_out = level_q;
    assign event_out = ev_q;
    assign overrun   = ovr_q;
endmodule
